hazard_stall_unit: RTL and testbench

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_stall_unit_if.sv | 39 +++
 rtl/hazard_stall_unit.sv | 89 ++++++++
 tb/tb_hazard_stall_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// Hazard-unit bus: ID/EX/MEM register-use info in, pipeline stall/flush controls out.
// master = pipeline datapath side, slave = hazard unit.
interface hazard_stall_unit_if;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic        ID_UsesRs;
    logic        ID_UsesRt;
    logic        ID_IsBranch;
    logic        ID_BranchTaken;
    logic [4:0]  EX_WriteReg;
    logic        EX_RegWrite;
    logic        EX_MemRead;
    logic [4:0]  MEM_WriteReg;
    logic        MEM_RegWrite;
    logic        MEM_MemRead;
    logic        PCWrite;
    logic        IFID_Write;
    logic        IDEX_Bubble;
    logic        IFID_Flush;
    logic        Stalled;
    logic [15:0] StallCount;
    logic [15:0] FlushCount;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_IsBranch, ID_BranchTaken,
               EX_WriteReg, EX_RegWrite, EX_MemRead,
               MEM_WriteReg, MEM_RegWrite, MEM_MemRead,
        input  PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, Stalled,
               StallCount, FlushCount
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_IsBranch, ID_BranchTaken,
               EX_WriteReg, EX_RegWrite, EX_MemRead,
               MEM_WriteReg, MEM_RegWrite, MEM_MemRead,
        output PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, Stalled,
               StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use / branch-operand hazard detector with a RUN/STALL FSM for multi-cycle stalls,
// same-cycle stall/flush controls and saturating event counters.
module hazard_stall_unit (
    input  logic                 Clk,
    input  logic                 Rst,
    hazard_stall_unit_if.slave   bus
);
    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    state_t      state;
    logic [1:0]  rem;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic ex_match, mem_match;
    logic [1:0] need;
    logic stall_now, flush_now;

    // Register 0 is hard-wired zero, so it never produces a dependency.
    always_comb begin
        ex_hit_rs  = bus.EX_RegWrite  && (bus.EX_WriteReg  != 5'd0) &&
                     (bus.EX_WriteReg  == bus.ID_Rs) && bus.ID_UsesRs;
        ex_hit_rt  = bus.EX_RegWrite  && (bus.EX_WriteReg  != 5'd0) &&
                     (bus.EX_WriteReg  == bus.ID_Rt) && bus.ID_UsesRt;
        mem_hit_rs = bus.MEM_RegWrite && (bus.MEM_WriteReg != 5'd0) &&
                     (bus.MEM_WriteReg == bus.ID_Rs) && bus.ID_UsesRs;
        mem_hit_rt = bus.MEM_RegWrite && (bus.MEM_WriteReg != 5'd0) &&
                     (bus.MEM_WriteReg == bus.ID_Rt) && bus.ID_UsesRt;
        ex_match   = ex_hit_rs  || ex_hit_rt;
        mem_match  = mem_hit_rs || mem_hit_rt;
    end

    // Branches compare in ID, so they also wait on ALU results and on loads still in MEM.
    always_comb begin
        need = 2'd0;
        if (bus.EX_MemRead && ex_match)
            need = 2'd1;
        if (bus.ID_IsBranch && bus.EX_RegWrite && !bus.EX_MemRead && ex_match)
            need = 2'd1;
        if (bus.ID_IsBranch && bus.MEM_MemRead && mem_match)
            need = 2'd1;
        if (bus.ID_IsBranch && bus.EX_MemRead && ex_match)
            need = 2'd2;
    end

    always_comb begin
        stall_now = !Rst && ((state == STALL) || (need != 2'd0));
        flush_now = !Rst && (state == RUN) && (need == 2'd0) &&
                    bus.ID_IsBranch && bus.ID_BranchTaken;
    end

    assign bus.PCWrite     = !stall_now;
    assign bus.IFID_Write  = !stall_now;
    assign bus.IDEX_Bubble = stall_now;
    assign bus.IFID_Flush  = flush_now;
    assign bus.Stalled     = !Rst && (state == STALL);
    assign bus.StallCount  = stall_cnt;
    assign bus.FlushCount  = flush_cnt;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= RUN;
            rem       <= 2'd0;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            case (state)
                RUN: begin
                    if (need != 2'd0) begin
                        rem <= need - 2'd1;
                        if ((need - 2'd1) != 2'd0)
                            state <= STALL;
                    end
                end
                STALL: begin
                    rem <= rem - 2'd1;
                    if (rem == 2'd1)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
            if (stall_now && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (flush_now && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: single-cycle vector table plus multi-cycle sequences.
module tb_hazard_stall_unit;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   exp_sc;
    int   exp_fc;

    hazard_stall_unit_if hif ();

    hazard_stall_unit dut (
        .Clk (clk),
        .Rst (rst),
        .bus (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       br;
        logic       tk;
        logic [4:0] exwr;
        logic       exrw;
        logic       exmr;
        logic [4:0] memwr;
        logic       memrw;
        logic       memmr;
        logic       stall;
        logic       flush;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        hif.ID_Rs          = v.rs;
        hif.ID_Rt          = v.rt;
        hif.ID_UsesRs      = v.urs;
        hif.ID_UsesRt      = v.urt;
        hif.ID_IsBranch    = v.br;
        hif.ID_BranchTaken = v.tk;
        hif.EX_WriteReg    = v.exwr;
        hif.EX_RegWrite    = v.exrw;
        hif.EX_MemRead     = v.exmr;
        hif.MEM_WriteReg   = v.memwr;
        hif.MEM_RegWrite   = v.memrw;
        hif.MEM_MemRead    = v.memmr;
    endtask

    task automatic chk_ctl(input string name, input logic stall, input logic flush, input logic stalled);
        chk({name, ".PCWrite"},     {31'd0, hif.PCWrite},     {31'd0, !stall});
        chk({name, ".IFID_Write"},  {31'd0, hif.IFID_Write},  {31'd0, !stall});
        chk({name, ".IDEX_Bubble"}, {31'd0, hif.IDEX_Bubble}, {31'd0, stall});
        chk({name, ".IFID_Flush"},  {31'd0, hif.IFID_Flush},  {31'd0, flush});
        chk({name, ".Stalled"},     {31'd0, hif.Stalled},     {31'd0, stalled});
    endtask

    task automatic chk_cnt(input string name);
        chk({name, ".StallCount"}, {16'd0, hif.StallCount}, exp_sc[31:0]);
        chk({name, ".FlushCount"}, {16'd0, hif.FlushCount}, exp_fc[31:0]);
    endtask

    vec_t idle, bal, bal_mem, lu;

    initial begin
        n_cmp = 0; n_err = 0; exp_sc = 0; exp_fc = 0;
        //           rs rt urs urt br tk exwr exrw exmr memwr memrw memmr stall flush
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};  // idle
        vecs[1]  = '{5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 1, 0};  // load-use on rs
        vecs[2]  = '{5, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0};  // rs not used
        vecs[3]  = '{1, 7, 0, 1, 0, 0, 7, 1, 1, 0, 0, 0, 1, 0};  // load-use on rt
        vecs[4]  = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};  // r0 load
        vecs[5]  = '{3, 0, 1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0};  // ALU dep, forwarded
        vecs[6]  = '{3, 0, 1, 0, 1, 0, 3, 1, 0, 0, 0, 0, 1, 0};  // branch on ALU result
        vecs[7]  = '{9, 0, 1, 0, 1, 0, 0, 0, 0, 9, 1, 1, 1, 0};  // branch on load in MEM
        vecs[8]  = '{9, 0, 1, 0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0};  // branch on ALU in MEM
        vecs[9]  = '{4, 6, 1, 1, 1, 1, 2, 1, 0, 3, 1, 1, 0, 1};  // taken, no hazard
        vecs[10] = '{4, 6, 1, 1, 1, 1, 6, 1, 0, 0, 0, 0, 1, 0};  // taken + stall
        vecs[11] = '{5, 0, 1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0};  // no write-enable
        vecs[12] = '{9, 0, 1, 0, 0, 0, 0, 0, 0, 9, 1, 1, 0, 0};  // MEM load, no branch
        vecs[13] = '{0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1};  // r0 in MEM, taken
        idle = vecs[0];

        // reset state
        rst = 1'b1;
        drive(idle);
        #2;
        chk_ctl("reset", 1'b0, 1'b0, 1'b0);
        chk_cnt("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk_ctl($sformatf("vec%0d", i), vecs[i].stall, vecs[i].flush, 1'b0);
            if (vecs[i].stall) exp_sc++;
            if (vecs[i].flush) exp_fc++;
            @(posedge clk);
            #1;
            chk_cnt($sformatf("vec%0d", i));
        end

        // branch after load: 2 stall cycles, then MEM-stage load still matches
        bal = '{0, 8, 0, 1, 1, 1, 8, 1, 1, 0, 0, 0, 0, 0};
        bal_mem = '{0, 8, 0, 1, 1, 1, 0, 0, 0, 8, 1, 1, 0, 0};
        @(negedge clk); drive(bal); #1;
        chk_ctl("bal.c1", 1'b1, 1'b0, 1'b0);
        @(negedge clk); drive(bal_mem); #1;
        chk_ctl("bal.c2", 1'b1, 1'b0, 1'b1);
        @(negedge clk); #1;
        chk_ctl("bal.c3", 1'b1, 1'b0, 1'b0);
        exp_sc += 3;
        @(negedge clk);
        bal_mem.memmr = 1'b0; bal_mem.memrw = 1'b0;
        drive(bal_mem); #1;
        chk_ctl("bal.c4", 1'b0, 1'b1, 1'b0);
        exp_fc += 1;
        @(posedge clk); #1;
        chk_cnt("bal.end");

        // reset in the middle of the first STALL cycle
        @(negedge clk); drive(bal);
        @(negedge clk); #1;
        chk_ctl("rst.pre", 1'b1, 1'b0, 1'b1);
        #1; rst = 1'b1; #1;
        exp_sc = 0; exp_fc = 0;
        chk_ctl("rst.mid", 1'b0, 1'b0, 1'b0);
        chk_cnt("rst.mid");
        drive(idle);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        chk_ctl("rst.after", 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_cnt("rst.after");

        // saturation: continuous load-use stalls
        lu = vecs[1];
        @(negedge clk); drive(lu);
        repeat (65535) @(posedge clk);
        #1;
        exp_sc = 16'hFFFF;
        chk_cnt("sat.65535");
        repeat (3) @(posedge clk);
        #1;
        chk_cnt("sat.plus3");
        chk_ctl("sat.ctl", 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
